// File: rtl/ysyx_22050854_wb_arbiter.sv
// ysyx_22050854_wb_arbiter
// Write-back arbiter that shares the register file's single write port
// between the EXU result (req0) and the LSU load result (req1).
// req1 wins by default. req0 is forced to win once it has been refused
// STARVE_LIMIT cycles in a row. Accepted writes pass through a one-cycle
// registered stage that drives rf_wen/rf_waddr/rf_wdata.
// Optional feature macro: YSYX_22050854_WB_FWD_EN enables the forwarding
// of the pending write to the read ports A/B.
module ysyx_22050854_wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [4:0]      req0_waddr,
  input  logic [XLEN-1:0] req0_wdata,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [4:0]      req1_waddr,
  input  logic [XLEN-1:0] req1_wdata,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [4:0]      rd_addr_a,
  input  logic [4:0]      rd_addr_b,
  output logic            fwd_hit_a,
  output logic            fwd_hit_b,
  output logic [XLEN-1:0] fwd_data,
  output logic [31:0]     wb_count
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]      r_scnt;
  logic            r_wen;
  logic [4:0]      r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic [31:0]     r_wb_count;

  logic            w_starve;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_xfer;
  logic [4:0]      w_sel_addr;
  logic [XLEN-1:0] w_sel_data;

  // Grant selection: LSU first unless the EXU has hit its starvation limit
  always_comb begin
    w_starve   = (r_scnt == LP_LIMIT);
    w_gnt1     = ~rst & req1_valid & ~(req0_valid & w_starve);
    w_gnt0     = ~rst & req0_valid & ~w_gnt1;
    w_xfer     = w_gnt0 | w_gnt1;
    w_sel_addr = w_gnt1 ? req1_waddr : req0_waddr;
    w_sel_data = w_gnt1 ? req1_wdata : req0_wdata;
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // Count consecutive refused cycles of a valid req0, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scnt <= '0;
    end else if (!req0_valid || w_gnt0) begin
      r_scnt <= '0;
    end else if (r_scnt != LP_LIMIT) begin
      r_scnt <= r_scnt + 4'd1;
    end
  end

  // Registered write stage; x0 transfers complete but never raise the enable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_xfer) begin
      r_wen   <= (w_sel_addr != 5'd0);
      r_waddr <= w_sel_addr;
      r_wdata <= w_sel_data;
    end else begin
      r_wen   <= 1'b0;
    end
  end

  // Committed write counter, bumps on every cycle the RF write enable is high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_count <= '0;
    end else if (r_wen) begin
      r_wb_count <= r_wb_count + 32'd1;
    end
  end

  assign rf_wen   = r_wen;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign wb_count = r_wb_count;

`ifdef YSYX_22050854_WB_FWD_EN
  // Forward the pending write to the read ports in the cycle before it lands
  always_comb begin
    fwd_hit_a = r_wen & (r_waddr == rd_addr_a) & (rd_addr_a != 5'd0);
    fwd_hit_b = r_wen & (r_waddr == rd_addr_b) & (rd_addr_b != 5'd0);
    fwd_data  = r_wdata;
  end
`else
  logic [9:0] w_unused_rd;
  assign w_unused_rd = {rd_addr_a, rd_addr_b};

  // Forwarding disabled: outputs tied off
  always_comb begin
    fwd_hit_a = 1'b0;
    fwd_hit_b = 1'b0;
    fwd_data  = '0;
  end
`endif

endmodule

// File: doc/ysyx_22050854_wb_arbiter.md
Name: ysyx_22050854_wb_arbiter

Overview:
Write-back arbiter for the register file's single write port. It shares that port between two requesters: req0 = EXU/ALU result and req1 = LSU load result. It uses valid/ready handshakes, a registered write stage and a starvation guard, and drives the register file's wen/waddr/wdata. It sits between the execute/LSU stages of the CPU and the register file instance.

Parameters:
XLEN, 64, register data width
STARVE_LIMIT, 3, consecutive cycles req0 may be refused before it is forced to win (range 1..15)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req0_valid  in  1  EXU write-back request
req0_ready  out  1  EXU request accepted this cycle (combinational)
req0_waddr  in  5  EXU destination register
req0_wdata  in  XLEN  EXU result
req1_valid  in  1  LSU write-back request
req1_ready  out  1  LSU request accepted this cycle (combinational)
req1_waddr  in  5  LSU destination register
req1_wdata  in  XLEN  LSU load data
rf_wen  out  1  register file write enable (registered)
rf_waddr  out  5  register file write address (registered)
rf_wdata  out  XLEN  register file write data (registered)
rd_addr_a  in  5  register file read port A address, for forwarding
rd_addr_b  in  5  register file read port B address, for forwarding
fwd_hit_a  out  1  port A address matches the pending write
fwd_hit_b  out  1  port B address matches the pending write
fwd_data  out  XLEN  pending write data (equals rf_wdata)
wb_count  out  32  number of committed non-x0 writes

Behaviour:
- Reset: synchronous, active-high, sampled on the clk rising edge. Clears rf_wen=0, rf_waddr=0, rf_wdata=0, wb_count=0 and the starvation counter.
- While rst=1, req0_ready=0 and req1_ready=0.
- Reset mid-operation: an in-flight write held in the output stage is dropped. No RF write occurs in the cycle after the reset edge.
- Arbitration (combinational, same cycle):
  - starve = (scnt == STARVE_LIMIT).
  - gnt1 = req1_valid & ~(req0_valid & starve).
  - gnt0 = req0_valid & ~gnt1.
  - reqN_ready = gntN. Ready never depends on the requester's own data.
- Handshake: a transfer occurs when valid&ready. A requester holds valid, waddr and wdata stable until accepted; this is a requester obligation and the arbiter does not check it. At most one transfer per cycle.
- Output stage: always accepts; the RF never stalls. Latency is 1 cycle: a transfer at edge N gives rf_wen/waddr/wdata valid during cycle N+1, and the RF writes at edge N+1.
- When no transfer occurs, rf_wen=0 next cycle. rf_waddr/rf_wdata hold their last values.
- x0 writes: the handshake completes (ready=1) but next-cycle rf_wen=0 and wb_count does not increment.
- Starvation counter scnt (4 bits):
  - 0 when req0_valid=0 or req0 is accepted.
  - +1 when req0_valid=1 and not accepted.
  - saturates at STARVE_LIMIT.
- Same-address conflict (both requesters target the same rd): no merging. The winner writes first and the loser writes later, so the loser's value is final.
- wb_count: +1 on every cycle with rf_wen=1. Wraps from 0xFFFFFFFF to 0.

Optional Feature:
YSYX_22050854_WB_FWD_EN
- Defined: fwd_hit_a = rf_wen & (rf_waddr == rd_addr_a) & (rd_addr_a != 0); fwd_hit_b likewise for rd_addr_b. fwd_data = rf_wdata. All combinational. Covers the cycle before the RF write lands.
- Undefined: fwd_hit_a = fwd_hit_b = 0 and fwd_data = 0. Ports stay present, no forwarding logic is generated.

Test Plan:
1. Reset: rst=1 for 2 cycles with both requests valid -> ready0=ready1=0, rf_wen=0, wb_count=0. One cycle after rst falls, the LSU write appears.
2. Single request: req0 x5=0x1234 -> req0_ready same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234; wb_count=1.
3. Contention: both valid continuously, req1 writes x6, STARVE_LIMIT=3 -> req1 granted 3 cycles, req0 granted on the 4th, then scnt resets to 0 and req1 wins again.
4. x0 drop: req1 x0=0xDEAD -> req1_ready=1; next cycle rf_wen=0; wb_count unchanged.
5. Forwarding (macro defined): req0 x6=0xABCD accepted, rd_addr_a=6 next cycle -> fwd_hit_a=1, fwd_data=0xABCD. With rd_addr_a=0 -> fwd_hit_a=0. Macro undefined -> fwd_hit_a=0.
6. Reset mid-write and wrap: assert rst in the cycle after an accept -> rf_wen=0 next cycle. Separately, force wb_count to 0xFFFFFFFF and commit one non-x0 write -> wb_count=0.
